univ_shift_reg: RTL
===================

// Module: univ_shift_reg
// PURPOSE
//   Parametrised universal shift register: hold, shift L/R, rotate L/R, parallel load, clear.
//   Single-step ops execute one per enabled clock. A burst engine runs a shift/rotate for
//   N cycles with a busy/done handshake. Serial bit-stream and data-alignment datapath element.
// PARAMETERS
//   WIDTH   8                      register width in bits (>=2)
//   CNT_W   $clog2(WIDTH+1)        width of shamt and the internal burst counter
// PORTS
//   clk         in   1       rising-edge clock
//   reset_n     in   1       asynchronous reset, active-low
//   en          in   1       clock enable for single-step ops; stalls a running burst when low
//   mode        in   3       000 hold, 001 shl, 010 shr, 011 rol, 100 ror, 101 load, 110 clear, 111 hold
//   par_in      in   WIDTH   parallel load data
//   ser_in_lsb  in   1       bit entering q[0] on shl
//   ser_in_msb  in   1       bit entering q[WIDTH-1] on shr
//   start       in   1       burst request, sampled only in IDLE
//   shamt       in   CNT_W   burst length in single-bit steps, 0..2^CNT_W-1
//   q           out  WIDTH   register contents
//   ser_out_msb out  1       q[WIDTH-1], combinational from q
//   ser_out_lsb out  1       q[0], combinational from q
//   busy        out  1       high while the FSM is in RUN
//   done        out  1       one-cycle registered pulse after a burst completes
// BEHAVIOUR
//   - Reset (reset_n=0, async): q=0, busy=0, done=0, counter=0, FSM=IDLE. Applies immediately.
//     A burst in flight is aborted with no done pulse.
//   - Step ops: shl q<={q[W-2:0],ser_in_lsb}; shr q<={ser_in_msb,q[W-1:1]};
//     rol q<={q[W-2:0],q[W-1]}; ror q<={q[0],q[W-1:1]}; load q<=par_in; clear q<=0.
//   - FSM states IDLE and RUN; busy = (state==RUN).
//   - IDLE, start=1, mode in 001..100: latch mode into burst_mode and shamt into cnt,
//     go to RUN. q does not change on this edge, and en is ignored on this edge.
//   - IDLE, start=1, other mode: start is ignored. Handled as a step op per en.
//   - IDLE, start=0, en=1: perform one step op per mode. en=0: q holds.
//   - RUN, cnt==0: go to IDLE and set done=1 on the same edge. q is unchanged (shamt=0 case).
//   - RUN, cnt!=0, en=1: apply burst_mode step, cnt<=cnt-1. If cnt==1, go to IDLE and set done=1.
//   - RUN, cnt!=0, en=0: stall; q and cnt hold.
//   - In RUN, the mode, start and par_in inputs are ignored. ser_in_* are sampled live on each step.
//   - done is high for exactly one cycle; the block is IDLE in that cycle and accepts commands.
//     done=0 in all other cycles.
//   - Latency: shamt=N with no stalls gives busy high N cycles after start (1 cycle if N=0).
//     done is high in the cycle after busy falls.
//   - shamt > WIDTH is legal. Rotates wrap modulo WIDTH; shifts fully flush to serial-input bits.
//   - No arithmetic overflow: cnt only decrements from a nonzero value, and never below 0.
// STRUCTURE
//   - Package usr_pkg: localparams for the mode encodings (MODE_HOLD..MODE_CLEAR) and the
//     FSM state encoding (ST_IDLE, ST_RUN).
//   - No sub-module. A local function step(q, mode, sin_lsb, sin_msb, par_in) returns the next q.
//     The step path and the burst path share this function.
// TESTING (WIDTH=8)
//   1. reset_n=0 with q nonzero -> q=8'h00, busy=0, done=0 with no clock edge; hold after release.
//   2. load 8'hA5 (en=1), then shl with ser_in_lsb=1 -> q=8'h4B; ser_out_msb was 1 before the shift.
//   3. q=8'hA5, start, mode=ror, shamt=3, en=1 -> busy high 3 cycles, q=8'hB4, done pulse 1 cycle.
//   4. start with shamt=0, mode=shl -> busy 1 cycle, done next cycle, q unchanged.
//   5. Burst rol shamt=4 on 8'h81 with en=0 for 2 mid-burst cycles -> busy 6 cycles, q=8'h18.
//   6. reset_n=0 in the 2nd cycle of a shamt=5 burst -> q=0, busy=0, no done;
//      a new start after release runs normally.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: operation modes and burst FSM states.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD     = 3'b000;
  localparam logic [2:0] MODE_SHL      = 3'b001;
  localparam logic [2:0] MODE_SHR      = 3'b010;
  localparam logic [2:0] MODE_ROL      = 3'b011;
  localparam logic [2:0] MODE_ROR      = 3'b100;
  localparam logic [2:0] MODE_LOAD     = 3'b101;
  localparam logic [2:0] MODE_CLEAR    = 3'b110;
  localparam logic [2:0] MODE_HOLD_ALT = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step ops and a counted shift/rotate burst engine.
// state   | meaning
// ST_IDLE | step ops per en/mode; a start with a shift/rotate mode launches a burst
// ST_RUN  | burst_mode applied once per enabled clock until the count reaches zero
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in_lsb,
  input  logic             ser_in_msb,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bmode_q, bmode_d;
  logic [0:0]       state_q, state_d;
  logic             done_q, done_d;
  logic             burst_req;

  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] cur,
    input logic [2:0]       m,
    input logic             sin_lsb,
    input logic             sin_msb,
    input logic [WIDTH-1:0] pin
  );
    case (m)
      MODE_SHL:   step = {cur[WIDTH-2:0], sin_lsb};
      MODE_SHR:   step = {sin_msb, cur[WIDTH-1:1]};
      MODE_ROL:   step = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ROR:   step = {cur[0], cur[WIDTH-1:1]};
      MODE_LOAD:  step = pin;
      MODE_CLEAR: step = '0;
      default:    step = cur;
    endcase
  endfunction

  assign burst_req = start && (mode inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR});

  always_comb begin
    q_d     = q_q;
    cnt_d   = cnt_q;
    bmode_d = bmode_q;
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (burst_req) begin
          bmode_d = mode;
          cnt_d   = shamt;
          state_d = ST_RUN;
        end else if (en) begin
          q_d = step(q_q, mode, ser_in_lsb, ser_in_msb, par_in);
        end
      end
      default: begin
        // A zero-length burst still spends one cycle in RUN so busy/done stay consistent.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (en) begin
          q_d   = step(q_q, bmode_q, ser_in_lsb, ser_in_msb, par_in);
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q     <= '0;
      cnt_q   <= '0;
      bmode_q <= MODE_HOLD;
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      bmode_q <= bmode_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign q           = q_q;
  assign ser_out_msb = q_q[WIDTH-1];
  assign ser_out_lsb = q_q[0];
  assign busy        = (state_q == ST_RUN);
  assign done        = done_q;

endmodule
